// File: rtl/tmb_tx_link_ctrl_if.sv
// tmb_tx_link_ctrl_if
// Bundles the restart request, the three GTX status inputs and the reset /
// status outputs of the trigger-fiber TX link sequencer.
// master: the sequencer (drives resets and status, observes GTX status)
// slave : the surroundings (control register, GTX, trigger fiber block)
interface tmb_tx_link_ctrl_if;
    logic       RESTART;
    logic       TRG_TX_PLL_LOCK;
    logic       TRG_TXRESETDONE;
    logic       TX_SYNC_DONE;
    logic       TRG_TX_PLLRST;
    logic       TRG_GTXTXRST;
    logic       TRG_RST;
    logic       LINK_UP;
    logic [2:0] STATE;
    logic [7:0] RETRY_CNT;
    logic       TMO_ERR;

    modport master (
        input  RESTART,
        input  TRG_TX_PLL_LOCK,
        input  TRG_TXRESETDONE,
        input  TX_SYNC_DONE,
        output TRG_TX_PLLRST,
        output TRG_GTXTXRST,
        output TRG_RST,
        output LINK_UP,
        output STATE,
        output RETRY_CNT,
        output TMO_ERR
    );

    modport slave (
        output RESTART,
        output TRG_TX_PLL_LOCK,
        output TRG_TXRESETDONE,
        output TX_SYNC_DONE,
        input  TRG_TX_PLLRST,
        input  TRG_GTXTXRST,
        input  TRG_RST,
        input  LINK_UP,
        input  STATE,
        input  RETRY_CNT,
        input  TMO_ERR
    );
endinterface

// File: rtl/tmb_tx_link_ctrl.sv
// tmb_tx_link_ctrl
// Power-up / recovery sequencer for the trigger-fiber GTX transmitter in the
// TRG_CLK80 domain: PLL reset -> wait lock -> GTX TX reset -> wait reset-done
// -> wait phase-sync -> comma-idle -> link up, with timeouts and auto-retry.
// Optional feature macro: TMB_TXLINK_LOSS_MON_EN
//   defined   : lock or reset-done lost in S_RUN for a debounce interval
//               restarts the sequence and counts as a retry
//   undefined : S_RUN is left only by RST or RESTART
module tmb_tx_link_ctrl #(
    parameter int SIM_SPEEDUP = 0,
    parameter int PLLRST_CYC  = 16,
    parameter int GTXRST_CYC  = 16,
    parameter int LOCK_TMO    = 800000,
    parameter int IDLE_CYC    = 256
) (
    input  logic               TRG_CLK80,
    input  logic               RST,
    tmb_tx_link_ctrl_if.master link
);

    // Effective counts; simulation speed-up collapses every interval to 64
    localparam int C_PLLRST = (SIM_SPEEDUP == 1) ? 64 : PLLRST_CYC;
    localparam int C_GTXRST = (SIM_SPEEDUP == 1) ? 64 : GTXRST_CYC;
    localparam int C_TMO    = (SIM_SPEEDUP == 1) ? 64 : LOCK_TMO;
    localparam int C_IDLE   = (SIM_SPEEDUP == 1) ? 64 : IDLE_CYC;

    // Dwell-counter terminal values (a state of N cycles ends at N-1)
    localparam logic [19:0] C_PLLRST_LAST = 20'(C_PLLRST - 1);
    localparam logic [19:0] C_GTXRST_LAST = 20'(C_GTXRST - 1);
    localparam logic [19:0] C_TMO_LAST    = 20'(C_TMO - 1);
    localparam logic [19:0] C_IDLE_LAST   = 20'(C_IDLE - 1);

`ifdef TMB_TXLINK_LOSS_MON_EN
    localparam int         C_LOSS      = (SIM_SPEEDUP == 1) ? 64 : 4;
    localparam logic [6:0] C_LOSS_LAST = 7'(C_LOSS - 1);
`endif

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WLOCK  = 3'd1,
        S_GTXRST = 3'd2,
        S_WDONE  = 3'd3,
        S_WSYNC  = 3'd4,
        S_IDLE   = 3'd5,
        S_RUN    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [19:0] r_cnt;
    logic        w_cntClr;
    logic        w_tmo;
    logic        w_loss;
    logic [7:0]  r_retry;
    logic        r_tmoErr;

    logic        r_lockMeta;
    logic        r_lockS;
    logic        r_doneMeta;
    logic        r_doneS;
    logic        r_syncMeta;
    logic        r_syncS;
    logic        w_lockClr;
    logic        w_doneClr;
    logic        w_syncClr;

    // A status input only means something once the block it reports on has
    // left reset, so each synchronizer is held clear until then. This makes
    // every wait state observe a fresh level (three cycles minimum).
    assign w_lockClr = RST || (r_state == S_PLLRST);
    assign w_doneClr = RST || (r_state inside {S_PLLRST, S_WLOCK, S_GTXRST});
    assign w_syncClr = RST || (r_state inside {S_PLLRST, S_WLOCK, S_GTXRST, S_WDONE});

    // Two-flop synchronizer for TX PLL lock
    always_ff @(posedge TRG_CLK80) begin
        if (w_lockClr) begin
            r_lockMeta <= 1'b0;
            r_lockS    <= 1'b0;
        end else begin
            r_lockMeta <= link.TRG_TX_PLL_LOCK;
            r_lockS    <= r_lockMeta;
        end
    end

    // Two-flop synchronizer for GTX TX reset-done
    always_ff @(posedge TRG_CLK80) begin
        if (w_doneClr) begin
            r_doneMeta <= 1'b0;
            r_doneS    <= 1'b0;
        end else begin
            r_doneMeta <= link.TRG_TXRESETDONE;
            r_doneS    <= r_doneMeta;
        end
    end

    // Two-flop synchronizer for TX phase-sync-done
    always_ff @(posedge TRG_CLK80) begin
        if (w_syncClr) begin
            r_syncMeta <= 1'b0;
            r_syncS    <= 1'b0;
        end else begin
            r_syncMeta <= link.TX_SYNC_DONE;
            r_syncS    <= r_syncMeta;
        end
    end

`ifdef TMB_TXLINK_LOSS_MON_EN
    logic       w_lossBad;
    logic [6:0] r_lossCnt;

    assign w_lossBad = !r_lockS || !r_doneS;

    // Debounce: counts consecutive S_RUN cycles with lock or reset-done low
    always_ff @(posedge TRG_CLK80) begin
        if (RST || (r_state != S_RUN) || !w_lossBad) begin
            r_lossCnt <= 7'd0;
        end else if (r_lossCnt != C_LOSS_LAST) begin
            r_lossCnt <= r_lossCnt + 7'd1;
        end
    end
`endif

    // Next-state decode; RESTART overrides any advance, timeout or loss
    always_comb begin
        w_nextState = r_state;
        w_tmo       = 1'b0;
        w_loss      = 1'b0;
        case (r_state)
            S_PLLRST: begin
                if (r_cnt == C_PLLRST_LAST) begin
                    w_nextState = S_WLOCK;
                end
            end
            S_WLOCK: begin
                if (r_lockS) begin
                    w_nextState = S_GTXRST;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_nextState = S_PLLRST;
                    w_tmo       = 1'b1;
                end
            end
            S_GTXRST: begin
                if (r_cnt == C_GTXRST_LAST) begin
                    w_nextState = S_WDONE;
                end
            end
            S_WDONE: begin
                if (!r_lockS) begin
                    w_nextState = S_PLLRST;
                end else if (r_doneS) begin
                    w_nextState = S_WSYNC;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_nextState = S_PLLRST;
                    w_tmo       = 1'b1;
                end
            end
            S_WSYNC: begin
                if (!r_lockS) begin
                    w_nextState = S_PLLRST;
                end else if (r_syncS) begin
                    w_nextState = S_IDLE;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_nextState = S_PLLRST;
                    w_tmo       = 1'b1;
                end
            end
            S_IDLE: begin
                if (r_cnt == C_IDLE_LAST) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
`ifdef TMB_TXLINK_LOSS_MON_EN
                if (w_lossBad && (r_lossCnt == C_LOSS_LAST)) begin
                    w_nextState = S_PLLRST;
                    w_loss      = 1'b1;
                end
`endif
            end
            default: begin
                w_nextState = S_PLLRST;
            end
        endcase
        if (link.RESTART) begin
            w_nextState = S_PLLRST;
            w_tmo       = 1'b0;
            w_loss      = 1'b0;
        end
    end

    // The dwell counter restarts whenever the sequence moves or is restarted
    assign w_cntClr = (w_nextState != r_state) || link.RESTART;

    // State register and dwell counter
    always_ff @(posedge TRG_CLK80) begin
        if (RST) begin
            r_state <= S_PLLRST;
            r_cnt   <= 20'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntClr ? 20'd0 : (r_cnt + 20'd1);
        end
    end

    // Saturating retry counter and sticky timeout flag
    always_ff @(posedge TRG_CLK80) begin
        if (RST) begin
            r_retry  <= 8'd0;
            r_tmoErr <= 1'b0;
        end else begin
            if ((w_tmo || w_loss) && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 8'd1;
            end
            if (link.RESTART) begin
                r_tmoErr <= 1'b0;
            end else if (w_tmo) begin
                r_tmoErr <= 1'b1;
            end
        end
    end

    // Outputs come only from registers, never from the status inputs
    assign link.TRG_TX_PLLRST = (r_state == S_PLLRST);
    assign link.TRG_GTXTXRST  = (r_state inside {S_PLLRST, S_WLOCK, S_GTXRST});
    assign link.TRG_RST       = (r_state != S_RUN);
    assign link.LINK_UP       = (r_state == S_RUN);
    assign link.STATE         = r_state;
    assign link.RETRY_CNT     = r_retry;
    assign link.TMO_ERR       = r_tmoErr;

endmodule

// File: tb/tb_tmb_tx_link_ctrl.sv
// tb_tmb_tx_link_ctrl
// Two sequencers share one clock: dutA with default counts, dutB with the
// 64-cycle simulation speed-up. Each stimulus step queues the output changes
// it should cause (cycle number + full output vector); a monitor per DUT
// pops an entry whenever that DUT's outputs change and compares them.
// Loss-monitor expectations follow TMB_TXLINK_LOSS_MON_EN.
module tb_tmb_tx_link_ctrl;

    typedef struct {
        int          cyc;
        logic [15:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    int   cyc = 0;
    int   nChecks = 0;
    int   nErrors = 0;
    int   evA = 0;
    int   evB = 0;
    int   retryA = 0;
    exp_t qA[$];
    exp_t qB[$];
    logic [15:0] prevA;
    logic [15:0] prevB;
    bit   seenA = 1'b0;
    bit   seenB = 1'b0;

    tmb_tx_link_ctrl_if ifA ();
    tmb_tx_link_ctrl_if ifB ();

    tmb_tx_link_ctrl dutA (
        .TRG_CLK80 (clk),
        .RST       (rstA),
        .link      (ifA.master)
    );

    tmb_tx_link_ctrl #(.SIM_SPEEDUP(1)) dutB (
        .TRG_CLK80 (clk),
        .RST       (rstB),
        .link      (ifB.master)
    );

    wire [15:0] obsA = {ifA.STATE, ifA.TRG_TX_PLLRST, ifA.TRG_GTXTXRST, ifA.TRG_RST,
                        ifA.LINK_UP, ifA.RETRY_CNT, ifA.TMO_ERR};
    wire [15:0] obsB = {ifB.STATE, ifB.TRG_TX_PLLRST, ifB.TRG_GTXTXRST, ifB.TRG_RST,
                        ifB.LINK_UP, ifB.RETRY_CNT, ifB.TMO_ERR};

    // 100 MHz-ish bench clock; only cycle counts matter
    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector for a state, from the state/output table
    function automatic logic [15:0] expVec(input int st, input int retry, input bit tmo);
        logic [2:0] s;
        logic [7:0] r;
        s = st[2:0];
        r = retry[7:0];
        return {s, (st == 0), (st <= 2), (st != 6), (st == 6), r, tmo};
    endfunction

    function automatic string fmtVec(input logic [15:0] v);
        return $sformatf("state=%0d pllrst=%b gtxrst=%b trgrst=%b up=%b retry=%0d tmo=%b",
                         v[15:13], v[12], v[11], v[10], v[9], v[8:1], v[0]);
    endfunction

    task automatic checkOutput(input string name, input int idx, input exp_t e,
                               input logic [15:0] obs);
        nChecks++;
        if ((obs !== e.vec) || ((e.cyc >= 0) && (e.cyc != cyc))) begin
            nErrors++;
            $display("[TB] FAIL %s event %0d: got %s at cycle %0d, expected %s at cycle %0d",
                     name, idx, fmtVec(obs), cyc, fmtVec(e.vec), e.cyc);
        end
    endtask

    // Monitor for dutA
    always @(negedge clk) begin
        if (!seenA || (obsA !== prevA)) begin
            seenA = 1'b1;
            prevA = obsA;
            if (qA.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL A unexpected event %0d: got %s at cycle %0d, expected no change",
                         evA, fmtVec(obsA), cyc);
            end else begin
                checkOutput("A", evA, qA.pop_front(), obsA);
            end
            evA++;
        end
    end

    // Monitor for dutB
    always @(negedge clk) begin
        if (!seenB || (obsB !== prevB)) begin
            seenB = 1'b1;
            prevB = obsB;
            if (qB.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL B unexpected event %0d: got %s at cycle %0d, expected no change",
                         evB, fmtVec(obsB), cyc);
            end else begin
                checkOutput("B", evB, qB.pop_front(), obsB);
            end
            evB++;
        end
    end

    task automatic expectEv(input bit isB, input int c, input int st, input int retry, input bit tmo);
        exp_t e;
        e.cyc = c;
        e.vec = expVec(st, retry, tmo);
        if (isB) qB.push_back(e);
        else     qA.push_back(e);
    endtask

    // Queue a full power-up walk whose S_PLLRST dwell starts at edge 'base'
    task automatic expectWalk(input bit isB, input int base, input int p, input int g,
                              input int idle, input int retry, input bit tmo, input bit withRun);
        expectEv(isB, base + p,             1, retry, tmo);
        expectEv(isB, base + p + 3,         2, retry, tmo);
        expectEv(isB, base + p + g + 3,     3, retry, tmo);
        expectEv(isB, base + p + g + 6,     4, retry, tmo);
        expectEv(isB, base + p + g + 9,     5, retry, tmo);
        if (withRun) expectEv(isB, base + p + g + 9 + idle, 6, retry, tmo);
    endtask

    task automatic toCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic applyStimulus(input int step);
        int t;
        int r;
        int e;
        case (step)
            // dutA: inputs high, RST released -> walk 0..6, LINK_UP after 297
            0: begin
                toCycle(4);
                rstA = 1'b0;
                r = cyc;
                expectWalk(1'b0, r, 16, 16, 256, 0, 1'b0, 1'b1);
                toCycle(r + 297 + 10);
            end
            // dutA: lock dropped 3 cycles in S_RUN -> no change either way
            1: begin
                t = cyc;
                ifA.TRG_TX_PLL_LOCK = 1'b0;
                toCycle(t + 3);
                ifA.TRG_TX_PLL_LOCK = 1'b1;
                toCycle(t + 20);
            end
            // dutA: lock dropped 4 cycles in S_RUN
            2: begin
                t = cyc;
                ifA.TRG_TX_PLL_LOCK = 1'b0;
                toCycle(t + 4);
                ifA.TRG_TX_PLL_LOCK = 1'b1;
`ifdef TMB_TXLINK_LOSS_MON_EN
                retryA = 1;
                expectEv(1'b0, t + 6, 0, 1, 1'b0);
                expectWalk(1'b0, t + 6, 16, 16, 256, 1, 1'b0, 1'b1);
                toCycle(t + 6 + 297 + 10);
`else
                retryA = 0;
                toCycle(t + 20);
`endif
            end
            // dutA: RESTART coincides with the 4th low-lock cycle, then RST in S_IDLE
            3: begin
                t = cyc;
                ifA.TRG_TX_PLL_LOCK = 1'b0;
                toCycle(t + 4);
                ifA.TRG_TX_PLL_LOCK = 1'b1;
                toCycle(t + 5);
                ifA.RESTART = 1'b1;
                toCycle(t + 6);
                ifA.RESTART = 1'b0;
                e = t + 6;
                expectEv(1'b0, e, 0, retryA, 1'b0);
                expectWalk(1'b0, e, 16, 16, 256, retryA, 1'b0, 1'b0);
                toCycle(e + 100);
                rstA = 1'b1;
                expectEv(1'b0, e + 101, 0, 0, 1'b0);
                toCycle(e + 110);
            end
            // dutB: lock held low -> 300 timeouts, retry saturates at 255
            4: begin
                ifB.TRG_TX_PLL_LOCK = 1'b0;
                rstB = 1'b0;
                r = cyc;
                for (int i = 1; i <= 300; i++) begin
                    expectEv(1'b1, r + 128 * (i - 1) + 64, 1, (i - 1 > 255) ? 255 : i - 1, i > 1);
                    expectEv(1'b1, r + 128 * i, 0, (i > 255) ? 255 : i, 1'b1);
                end
                toCycle(r + 128 * 300);
                rstB = 1'b1;
                expectEv(1'b1, r + 128 * 300 + 1, 0, 0, 1'b0);
                toCycle(r + 128 * 300 + 2);
            end
            // dutB: sync too late -> timeout; next attempt sync after 17 cycles -> up; RESTART
            5: begin
                ifB.TRG_TX_PLL_LOCK = 1'b1;
                ifB.TRG_TXRESETDONE = 1'b1;
                ifB.TX_SYNC_DONE    = 1'b0;
                rstB = 1'b0;
                r = cyc;
                expectWalk(1'b1, r, 64, 64, 64, 0, 1'b0, 1'b0);
                e = r + 134 + 64;
                // the 5th walk entry (S_IDLE) never happens on this attempt
                void'(qB.pop_back());
                expectEv(1'b1, e, 0, 1, 1'b1);
                toCycle(r + 134 + 100);
                ifB.TX_SYNC_DONE = 1'b1;
                toCycle(r + 134 + 106);
                ifB.TX_SYNC_DONE = 1'b0;
                expectEv(1'b1, e + 64,  1, 1, 1'b1);
                expectEv(1'b1, e + 67,  2, 1, 1'b1);
                expectEv(1'b1, e + 131, 3, 1, 1'b1);
                expectEv(1'b1, e + 134, 4, 1, 1'b1);
                expectEv(1'b1, e + 154, 5, 1, 1'b1);
                expectEv(1'b1, e + 218, 6, 1, 1'b1);
                toCycle(e + 151);
                ifB.TX_SYNC_DONE = 1'b1;
                toCycle(e + 230);
                ifB.RESTART = 1'b1;
                toCycle(e + 231);
                ifB.RESTART = 1'b0;
                expectEv(1'b1, e + 231, 0, 1, 1'b0);
                expectWalk(1'b1, e + 231, 64, 64, 64, 1, 1'b0, 1'b1);
                toCycle(e + 231 + 201 + 10);
            end
            default: ;
        endcase
    endtask

    initial begin
        exp_t e;
        rstA = 1'b1;
        rstB = 1'b1;
        ifA.RESTART = 1'b0;
        ifA.TRG_TX_PLL_LOCK = 1'b1;
        ifA.TRG_TXRESETDONE = 1'b1;
        ifA.TX_SYNC_DONE    = 1'b1;
        ifB.RESTART = 1'b0;
        ifB.TRG_TX_PLL_LOCK = 1'b1;
        ifB.TRG_TXRESETDONE = 1'b1;
        ifB.TX_SYNC_DONE    = 1'b1;
        // reset state of both DUTs, cycle not checked
        expectEv(1'b0, -1, 0, 0, 1'b0);
        expectEv(1'b1, -1, 0, 0, 1'b0);
        @(negedge clk);
        for (int s = 0; s <= 5; s++) applyStimulus(s);
        toCycle(cyc + 20);
        while (qA.size() > 0) begin
            e = qA.pop_front();
            nChecks++;
            nErrors++;
            $display("[TB] FAIL A missing event: expected %s at cycle %0d, got no change",
                     fmtVec(e.vec), e.cyc);
        end
        while (qB.size() > 0) begin
            e = qB.pop_front();
            nChecks++;
            nErrors++;
            $display("[TB] FAIL B missing event: expected %s at cycle %0d, got no change",
                     fmtVec(e.vec), e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/tmb_tx_link_ctrl.md
# tmb_tx_link_ctrl

Power-up and recovery sequencer for the trigger-fiber GTX transmitter path. It drives the TX PLL reset, the GTX TX reset and the trigger-link reset, and waits for PLL lock, TX reset-done and TX phase-sync-done in order. It then holds the link in comma-idle for a fixed interval before declaring it up. It sits beside the trigger fiber output block in the TRG_CLK80 domain and replaces the loose software-driven reset bits, with timeouts, automatic retry and status outputs for the control registers.

## Interface

Parameters:
- SIM_SPEEDUP, 0, when 1 every timeout/hold count is forced to 64 cycles
- PLLRST_CYC, 16, cycles TRG_TX_PLLRST is held in S_PLLRST (2..2^20-1)
- GTXRST_CYC, 16, cycles TRG_GTXTXRST is held alone in S_GTXRST
- LOCK_TMO, 800000, max cycles waiting in any S_W* state (10 ms at 80 MHz)
- IDLE_CYC, 256, cycles of comma-idle (TRG_RST high) after sync before link-up

Ports:
- TRG_CLK80  in  1  sole clock, free-running 80 MHz fabric clock
- RST  in  1  synchronous, active-high reset
- RESTART  in  1  one-cycle pulse from the control register; restarts the sequence
- TRG_TX_PLL_LOCK  in  1  GTX TX PLL lock, asynchronous
- TRG_TXRESETDONE  in  1  GTX TX reset done, asynchronous
- TX_SYNC_DONE  in  1  TX phase-alignment done, asynchronous
- TRG_TX_PLLRST  out  1  to GTX PLLTXRESET
- TRG_GTXTXRST  out  1  to GTX GTXTXRESET
- TRG_RST  out  1  trigger link reset; high makes the transmitter send 50BC commas
- LINK_UP  out  1  high only in S_RUN
- STATE  out  3  current state encoding
- RETRY_CNT  out  8  number of timeout-triggered retries, saturating
- TMO_ERR  out  1  sticky; set on any timeout, cleared by RST or RESTART

## Operation

- The three asynchronous inputs each pass through a two-flop synchronizer. All decisions use the synchronized versions (lock_s, done_s, sync_s).
- States, with STATE encoding:
  - S_PLLRST=0: PLLRST=1, GTXTXRST=1, TRG_RST=1; after PLLRST_CYC cycles go to S_WLOCK.
  - S_WLOCK=1: GTXTXRST=1, TRG_RST=1; on lock_s go to S_GTXRST.
  - S_GTXRST=2: GTXTXRST=1, TRG_RST=1; after GTXRST_CYC cycles go to S_WDONE.
  - S_WDONE=3: TRG_RST=1; on done_s go to S_WSYNC.
  - S_WSYNC=4: TRG_RST=1; on sync_s go to S_IDLE.
  - S_IDLE=5: TRG_RST=1; after IDLE_CYC cycles go to S_RUN.
  - S_RUN=6: all resets 0, LINK_UP=1.
- Timeout: in S_WLOCK, S_WDONE or S_WSYNC, when the dwell counter reaches LOCK_TMO-1 without the awaited input, go to S_PLLRST, increment RETRY_CNT (saturating at 255) and set TMO_ERR.
- A single 20-bit dwell counter clears on every state change and increments every cycle while the state is held. Comparisons are against a parameter minus 1.
- In S_WDONE/S_WSYNC, loss of lock_s goes to S_PLLRST. This is not counted as a retry.
- RESTART in any state goes to S_PLLRST, clears TMO_ERR and leaves RETRY_CNT unchanged.
- RESTART has priority over a timeout or a wait-condition advance occurring in the same cycle.
- All outputs are decoded only from the state register; inputs have no combinational path to outputs.

## Timing

- Reset values: state S_PLLRST, TRG_TX_PLLRST=1, TRG_GTXTXRST=1, TRG_RST=1, LINK_UP=0, STATE=0, RETRY_CNT=0, TMO_ERR=0, counter=0.
- RST asserted mid-sequence takes effect at the next edge, identical to power-up.
- A timed state lasts exactly N cycles (N = PLLRST_CYC, GTXRST_CYC or IDLE_CYC).
- Input-to-state latency: the awaited input is seen 2 cycles after the asynchronous edge (synchronizer), then the state advances on the following edge.
- Minimum RST-release to LINK_UP, with inputs already high: PLLRST_CYC + GTXRST_CYC + IDLE_CYC + 3 wait states, each 3 cycles including the synchronizer.
- With SIM_SPEEDUP=1, all five counts (PLLRST_CYC, GTXRST_CYC, LOCK_TMO, IDLE_CYC and the TXLOSS debounce) equal 64.

## Configuration

- TMB_TXLINK_LOSS_MON_EN defined: in S_RUN, lock_s or done_s low for 4 consecutive cycles goes to S_PLLRST and increments RETRY_CNT. LINK_UP drops on the next edge.
- TMB_TXLINK_LOSS_MON_EN undefined: S_RUN is left only by RST or RESTART; lock_s and done_s are ignored there.

## Test plan

- SIM_SPEEDUP=0 defaults, inputs tied high, RST released -> STATE walks 0..6; PLLRST high 16 cycles; LINK_UP rises 16+16+256+9=297 cycles after RST falls.
- PLL lock held low, SIM_SPEEDUP=1 -> timeout after 64 cycles in S_WLOCK; RETRY_CNT=1, TMO_ERR=1, PLLRST reasserts. 300 forced retries -> RETRY_CNT=255.
- TX_SYNC_DONE asserted 100 cycles late in S_WSYNC, SIM_SPEEDUP=1 -> timeout and retry. Then assert it within 20 cycles -> LINK_UP with TMO_ERR still 1 until RESTART.
- RESTART pulse in S_RUN in the same cycle as lock loss (macro defined) -> S_PLLRST, TMO_ERR=0, RETRY_CNT unchanged.
- Macro defined, lock dropped for 3 cycles in S_RUN -> LINK_UP stays 1. Dropped for 4 cycles -> LINK_UP=0 and RETRY_CNT increments. Macro undefined, same stimulus -> LINK_UP stays 1.
- RST pulsed while in S_IDLE -> next cycle all reset outputs are 1, STATE=0, RETRY_CNT=0.
